// File: rtl/matrix_io_pkg.sv
// Shared definitions for the matrix I/O path: defaults, ASCII codes, loader
// states and the column-major SRAM address helper.
package matrix_io_pkg;
  localparam int SIZE       = 4;
  localparam int DATA_WIDTH = 18;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} loader_state_t;

  // Offset of element (m, r, c) with each matrix stored column-major; lg = log2(SIZE).
  function automatic logic [31:0] col_major_addr(input logic [31:0] m, input logic [31:0] r,
                                                 input logic [31:0] c, input int lg);
    return (m << (2 * lg)) | (c << lg) | r;
  endfunction
endpackage

// File: rtl/uart_matrix_loader_if.sv
// Control, UART-receive and SRAM-write signals of the matrix loader.
interface uart_matrix_loader_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int WC_WIDTH   = 6
);
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [WC_WIDTH-1:0]   word_count;

  modport master (output start, rx_valid, rx_byte,
                  input  sram_we, sram_addr, sram_data, busy, done, err, word_count);
  modport slave  (input  start, rx_valid, rx_byte,
                  output sram_we, sram_addr, sram_data, busy, done, err, word_count);
endinterface

// File: rtl/hex_ascii_classify.sv
// Combinational ASCII classifier: hex digit (with value) or token separator.
module hex_ascii_classify
  import matrix_io_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic       is_sep,
  output logic [3:0] nibble
);
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h30);
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h37);
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h57);
    end
    is_sep = ch inside {ASCII_SP, ASCII_TAB, ASCII_COMMA, ASCII_CR, ASCII_LF};
  end
endmodule

// File: rtl/uart_matrix_loader.sv
// Parses hex tokens from the UART byte stream and writes them as matrix
// elements into SRAM in column-major order.
module uart_matrix_loader #(
  parameter int SIZE         = matrix_io_pkg::SIZE,
  parameter int NUM_MATRICES = 2,
  parameter int DATA_WIDTH   = matrix_io_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = 11,
  parameter int MAX_DIGITS   = 5,
  parameter int BASE_ADDR    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_matrix_loader_if.slave  bus
);
  import matrix_io_pkg::*;

  localparam int TOTAL = NUM_MATRICES * SIZE * SIZE;
  localparam int WC_W  = $clog2(TOTAL) + 1;
  localparam int LG    = $clog2(SIZE);
  localparam int ACC_W = 4 * MAX_DIGITS;
  localparam int ND_W  = $clog2(MAX_DIGITS + 1);

  loader_state_t         state;
  logic [ACC_W-1:0]      acc;
  logic [ND_W-1:0]       ndig;
  logic [WC_W-1:0]       wc;
  logic                  we_q, busy_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  is_hex, is_sep;
  logic [3:0]            nibble;
  logic [31:0]           t;

  hex_ascii_classify u_cls (.ch(bus.rx_byte), .is_hex(is_hex), .is_sep(is_sep), .nibble(nibble));

  // Word count doubles as the token index; split it into matrix/row/col fields.
  assign t         = 32'(wc);
  assign addr_next = ADDR_WIDTH'(32'(BASE_ADDR) +
                     col_major_addr(t >> (2 * LG), (t >> LG) & 32'(SIZE - 1), t & 32'(SIZE - 1), LG));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      ndig   <= '0;
      wc     <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (bus.start) begin
        state  <= S_RECV;
        acc    <= '0;
        ndig   <= '0;
        wc     <= '0;
        busy_q <= 1'b1;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        case (state)
          S_RECV: if (bus.rx_valid) begin
            if (is_hex) begin
              if (ndig == ND_W'(MAX_DIGITS)) begin
                state  <= S_ERR;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
              end else begin
                acc  <= {acc[ACC_W-5:0], nibble};
                ndig <= ndig + 1'b1;
              end
            end else if (is_sep) begin
              // Only the first separator after digits commits a token.
              if (ndig != '0) begin
                data_q <= acc[DATA_WIDTH-1:0];
                addr_q <= addr_next;
                we_q   <= 1'b1;
                state  <= S_WRITE;
              end
            end else begin
              state  <= S_ERR;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end
          end
          S_WRITE: begin
            if (bus.rx_valid) begin
              state  <= S_ERR;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end else begin
              acc  <= '0;
              ndig <= '0;
              wc   <= wc + 1'b1;
              if (wc + 1'b1 == WC_W'(TOTAL)) begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state <= S_RECV;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_data  = data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.word_count = wc;
endmodule
